// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt controller: FSM states, register
// offsets and STATUS field positions.
package intc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SVC  = 2'd2
  } state_t;

  localparam logic [1:0] REG_MASK = 2'd0;
  localparam logic [1:0] REG_PEND = 2'd1;
  localparam logic [1:0] REG_STAT = 2'd2;
  localparam logic [1:0] REG_EOI  = 2'd3;

  localparam int unsigned STAT_IRQ_ID_LSB = 0;

  function automatic int unsigned stat_isr_lsb(int unsigned id_w);
    return id_w;
  endfunction

  function automatic int unsigned stat_state_lsb(int unsigned id_w);
    return 2 * id_w;
  endfunction

  function automatic int unsigned stat_req_bit(int unsigned id_w);
    return 2 * id_w + 2;
  endfunction

endpackage

// File: rtl/intc_prio_enc.sv
// Lowest-index-first priority encoder: reports whether any request is set
// and the index of the lowest set bit (0 when none).
module intc_prio_enc
  import intc_pkg::*;
#(
  parameter int unsigned N = 6,
  parameter int unsigned W = 3
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [W-1:0] idx
);

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req[i] && !valid) begin
        valid = 1'b1;
        idx   = W'(i);
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: pending/mask registers, priority select and a
// req/ack/EOI handshake. Define INTC_EDGE_EN for rising-edge source capture.
module int_ctrl
  import intc_pkg::*;
#(
  parameter int unsigned N_SRC = 6,
  parameter int unsigned ID_W  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] hw_int,
  input  logic             reg_we,
  input  logic [1:0]       reg_addr,
  input  logic [31:0]      reg_wdata,
  output logic [31:0]      reg_rdata,
  output logic             irq_req,
  output logic [ID_W-1:0]  irq_id,
  input  logic             irq_ack,
  output logic             in_service
);

  localparam int unsigned ISR_LSB = stat_isr_lsb(ID_W);
  localparam int unsigned ST_LSB  = stat_state_lsb(ID_W);
  localparam int unsigned REQ_BIT = stat_req_bit(ID_W);

  state_t            state, state_n;
  logic [N_SRC-1:0]  mask, pending, active, src_event, w1c, ack_clr;
  logic [ID_W-1:0]   isr_id, top_id;
  logic              top_vld, ack_take, eoi_wr;
  logic [31:0]       status;
  logic              unused_wdata;

  assign unused_wdata = ^reg_wdata[31:N_SRC];

`ifdef INTC_EDGE_EN
  logic [N_SRC-1:0] hw_int_q;

  always_ff @(posedge clk) begin
    if (reset) hw_int_q <= '0;
    else       hw_int_q <= hw_int;
  end

  assign src_event = hw_int & ~hw_int_q;
`else
  assign src_event = hw_int;
`endif

  assign active = pending & mask;

  intc_prio_enc #(.N(N_SRC), .W(ID_W)) u_prio (
    .req   (active),
    .valid (top_vld),
    .idx   (top_id)
  );

  assign irq_id  = top_id;
  assign w1c     = (reg_we && reg_addr == REG_PEND) ? reg_wdata[N_SRC-1:0] : '0;
  assign eoi_wr  = reg_we && (reg_addr == REG_EOI);
  assign ack_clr = ack_take ? (N_SRC'(1) << top_id) : '0;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  // irq_req is qualified by a live request so a W1C/mask-out drops it at once,
  // before the FSM has stepped back to IDLE.
  always_comb begin
    state_n    = state;
    irq_req    = 1'b0;
    in_service = 1'b0;
    ack_take   = 1'b0;
    case (state)
      ST_IDLE: if (top_vld) state_n = ST_REQ;
      ST_REQ: begin
        irq_req = top_vld;
        if (!top_vld) begin
          state_n = ST_IDLE;
        end else if (irq_ack) begin
          ack_take = 1'b1;
          state_n  = ST_SVC;
        end
      end
      ST_SVC: begin
        in_service = 1'b1;
        if (eoi_wr) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // New events are OR-ed in after the clears so a same-cycle set always wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask    <= '0;
      pending <= '0;
      isr_id  <= '0;
    end else begin
      if (reg_we && reg_addr == REG_MASK) mask <= reg_wdata[N_SRC-1:0];
      pending <= (pending & ~(w1c | ack_clr)) | src_event;
      if (ack_take) isr_id <= top_id;
    end
  end

  always_comb begin
    status                             = '0;
    status[STAT_IRQ_ID_LSB +: ID_W]    = top_id;
    status[ISR_LSB +: ID_W]            = isr_id;
    status[ST_LSB +: 2]                = state;
    status[REQ_BIT]                    = irq_req;
  end

  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      REG_MASK: reg_rdata[N_SRC-1:0] = mask;
      REG_PEND: reg_rdata[N_SRC-1:0] = pending;
      REG_STAT: reg_rdata            = status;
      default:  reg_rdata            = '0;
    endcase
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: a vector table for the basic handshake plus
// hand-written sequences for priority preemption, W1C collisions, reset and level/edge.
module tb_int_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  hw_int;
  logic        reg_we;
  logic [1:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        irq_req;
  logic [2:0]  irq_id;
  logic        irq_ack;
  logic        in_service;

  int total = 0;
  int bad   = 0;

  int_ctrl #(.N_SRC(6), .ID_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .hw_int     (hw_int),
    .reg_we     (reg_we),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_rdata  (reg_rdata),
    .irq_req    (irq_req),
    .irq_id     (irq_id),
    .irq_ack    (irq_ack),
    .in_service (in_service)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  hw;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        ack;
    logic [1:0]  rd;
    logic        e_req;
    logic [2:0]  e_id;
    logic        e_svc;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(logic [5:0] hw, logic we, logic [1:0] addr, logic [31:0] wdata,
                              logic ack, logic [1:0] rd, logic e_req, logic [2:0] e_id,
                              logic e_svc, logic [31:0] e_rd);
    vec_t v;
    v.hw = hw; v.we = we; v.addr = addr; v.wdata = wdata; v.ack = ack; v.rd = rd;
    v.e_req = e_req; v.e_id = e_id; v.e_svc = e_svc; v.e_rd = e_rd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs, clock once, return inputs to idle.
  task automatic step(input logic [5:0] hw, input logic we, input logic [1:0] addr,
                      input logic [31:0] wdata, input logic ack);
    hw_int = hw; reg_we = we; reg_addr = addr; reg_wdata = wdata; irq_ack = ack;
    tick();
    hw_int = '0; reg_we = 1'b0; reg_wdata = '0; irq_ack = 1'b0;
  endtask

  task automatic rd(input logic [1:0] addr, output logic [31:0] data);
    reg_addr = addr;
    #1;
    data = reg_rdata;
  endtask

  task automatic chk_out(input string tag, input logic e_req, input logic [2:0] e_id,
                         input logic e_svc);
    chk({tag, ".irq_req"}, 32'(irq_req), 32'(e_req));
    chk({tag, ".irq_id"}, 32'(irq_id), 32'(e_id));
    chk({tag, ".in_service"}, 32'(in_service), 32'(e_svc));
  endtask

  initial begin
    logic [31:0] d;

    vecs[0]  = mk(6'h00, 0, 2'd0, 32'h0,  0, 2'd1, 0, 3'd0, 0, 32'h000);
    vecs[1]  = mk(6'h01, 0, 2'd0, 32'h0,  0, 2'd1, 0, 3'd0, 0, 32'h001);
    vecs[2]  = mk(6'h00, 0, 2'd0, 32'h0,  0, 2'd2, 0, 3'd0, 0, 32'h000);
    vecs[3]  = mk(6'h00, 1, 2'd0, 32'h3F, 0, 2'd0, 0, 3'd0, 0, 32'h03F);
    vecs[4]  = mk(6'h00, 0, 2'd0, 32'h0,  0, 2'd2, 1, 3'd0, 0, 32'h140);
    vecs[5]  = mk(6'h00, 0, 2'd0, 32'h0,  1, 2'd2, 0, 3'd0, 1, 32'h080);
    vecs[6]  = mk(6'h00, 1, 2'd3, 32'h0,  0, 2'd2, 0, 3'd0, 0, 32'h000);
    vecs[7]  = mk(6'h06, 0, 2'd0, 32'h0,  0, 2'd1, 0, 3'd1, 0, 32'h006);
    vecs[8]  = mk(6'h00, 0, 2'd0, 32'h0,  0, 2'd2, 1, 3'd1, 0, 32'h141);
    vecs[9]  = mk(6'h00, 0, 2'd0, 32'h0,  1, 2'd2, 0, 3'd2, 1, 32'h08A);
    vecs[10] = mk(6'h00, 0, 2'd0, 32'h0,  0, 2'd1, 0, 3'd2, 1, 32'h004);
    vecs[11] = mk(6'h00, 0, 2'd0, 32'h0,  1, 2'd1, 0, 3'd2, 1, 32'h004);
    vecs[12] = mk(6'h00, 1, 2'd3, 32'h0,  0, 2'd2, 0, 3'd2, 0, 32'h00A);
    vecs[13] = mk(6'h00, 0, 2'd0, 32'h0,  0, 2'd2, 1, 3'd2, 0, 32'h14A);
    vecs[14] = mk(6'h00, 1, 2'd3, 32'h0,  0, 2'd2, 1, 3'd2, 0, 32'h14A);
    vecs[15] = mk(6'h00, 0, 2'd0, 32'h0,  1, 2'd2, 0, 3'd0, 1, 32'h090);
    vecs[16] = mk(6'h00, 1, 2'd3, 32'h0,  0, 2'd1, 0, 3'd0, 0, 32'h000);

    reset = 1'b1; hw_int = '0; reg_we = 1'b0; reg_addr = '0; reg_wdata = '0; irq_ack = 1'b0;
    tick();
    tick();
    chk_out("reset", 0, 3'd0, 0);
    chk("reset.rdata", reg_rdata, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      step(vecs[i].hw, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].ack);
      rd(vecs[i].rd, d);
      chk_out($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_id, vecs[i].e_svc);
      chk($sformatf("vec%0d.rdata", i), d, vecs[i].e_rd);
    end

    // Higher-priority arrival while requesting
    step(6'h08, 0, 2'd0, 32'h0, 0);
    step(6'h00, 0, 2'd0, 32'h0, 0);
    chk_out("preempt.before", 1, 3'd3, 0);
    step(6'h01, 0, 2'd0, 32'h0, 0);
    chk_out("preempt.after", 1, 3'd0, 0);
    step(6'h00, 0, 2'd0, 32'h0, 1);
    rd(2'd2, d);
    chk("preempt.status", d, 32'h083);
    rd(2'd1, d);
    chk("preempt.pend", d, 32'h008);
    step(6'h00, 1, 2'd1, 32'h3F, 0);
    step(6'h00, 1, 2'd3, 32'h0, 0);
    step(6'h00, 0, 2'd0, 32'h0, 0);
    rd(2'd1, d);
    chk("preempt.clean", d, 32'h0);
    chk("preempt.clean_req", 32'(irq_req), 32'h0);

    // Set and W1C of the same bit in one cycle, then W1C of the only request
    step(6'h02, 1, 2'd1, 32'h02, 0);
    rd(2'd1, d);
    chk("collide.pend", d, 32'h002);
    step(6'h00, 0, 2'd0, 32'h0, 0);
    chk_out("w1c.req", 1, 3'd1, 0);
    step(6'h00, 1, 2'd1, 32'h02, 0);
    chk("w1c.req_drop", 32'(irq_req), 32'h0);
    step(6'h00, 0, 2'd0, 32'h0, 0);
    rd(2'd2, d);
    chk("w1c.status_idle", d, 32'h0);

    // Reset while in service with pending sources
    step(6'h05, 0, 2'd0, 32'h0, 0);
    step(6'h00, 0, 2'd0, 32'h0, 0);
    step(6'h00, 0, 2'd0, 32'h0, 1);
    step(6'h01, 0, 2'd0, 32'h0, 0);
    rd(2'd1, d);
    chk("rst.pend_before", d, 32'h005);
    chk("rst.svc_before", 32'(in_service), 32'h1);
    reset = 1'b1; irq_ack = 1'b1;
    tick();
    reset = 1'b0; irq_ack = 1'b0;
    chk_out("rst.after", 0, 3'd0, 0);
    rd(2'd0, d);
    chk("rst.mask", d, 32'h0);
    rd(2'd1, d);
    chk("rst.pend", d, 32'h0);
    rd(2'd2, d);
    chk("rst.status", d, 32'h0);

    // Held-high source across ack and EOI
    step(6'h00, 1, 2'd0, 32'h3F, 0);
    hw_int = 6'h04;
    tick();
    tick();
    chk_out("hold.req", 1, 3'd2, 0);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk("hold.svc", 32'(in_service), 32'h1);
    reg_we = 1'b1; reg_addr = 2'd3;
    tick();
    reg_we = 1'b0;
    tick();
`ifdef INTC_EDGE_EN
    chk_out("hold.after_eoi", 0, 3'd0, 0);
`else
    chk_out("hold.after_eoi", 1, 3'd2, 0);
`endif
    for (int i = 0; i < 5; i++) tick();
`ifdef INTC_EDGE_EN
    chk_out("hold.end", 0, 3'd0, 0);
`else
    chk_out("hold.end", 1, 3'd2, 0);
`endif
    hw_int = '0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
